// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, holds the fetched
// word for decode, discards flushed responses and latches sticky fetch faults.
module fetch_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  output logic        pc_load,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        instr_valid,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {IDLE, FETCH, DISCARD, HOLD, FAULT} state_t;

  state_t          state, next_state;
  logic [63:0]     addr, next_addr;
  logic [CW-1:0]   cnt;
  logic            load_addr, clr_cnt, cnt_en, cap_instr, set_fault, timed_out, req_nxt;
  logic [1:0]      cause_nxt;

  assign imem_addr = addr;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_addr  = 1'b0;
    clr_cnt    = 1'b0;
    cap_instr  = 1'b0;
    set_fault  = 1'b0;
    cause_nxt  = 2'b00;
    pc_load    = 1'b0;
    case (state)
      IDLE: begin
        next_state = FETCH;
        load_addr  = 1'b1;
        clr_cnt    = 1'b1;
      end
      FETCH: begin
        if (addr[1:0] != 2'b00) begin
          next_state = FAULT;
          set_fault  = 1'b1;
          cause_nxt  = CAUSE_MISALIGN;
        end else if (imem_ack) begin
          if (flush) begin
            // Response dropped; re-enter FETCH at the current pc.
            next_state = FETCH;
            load_addr  = 1'b1;
            clr_cnt    = 1'b1;
          end else begin
            next_state = HOLD;
            cap_instr  = 1'b1;
          end
        end else if (flush) begin
          next_state = DISCARD;
          clr_cnt    = 1'b1;
        end else if (timed_out) begin
          next_state = FAULT;
          set_fault  = 1'b1;
          cause_nxt  = CAUSE_TIMEOUT;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          next_state = FETCH;
          load_addr  = 1'b1;
          clr_cnt    = 1'b1;
        end else if (timed_out) begin
          next_state = FAULT;
          set_fault  = 1'b1;
          cause_nxt  = CAUSE_TIMEOUT;
        end
      end
      HOLD: begin
        // flush wins over dec_ready and suppresses the pc_load strobe.
        if (flush) begin
          next_state = FETCH;
          load_addr  = 1'b1;
          clr_cnt    = 1'b1;
        end else if (dec_ready) begin
          pc_load    = 1'b1;
          next_state = FETCH;
          load_addr  = 1'b1;
          clr_cnt    = 1'b1;
        end
      end
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    next_addr = load_addr ? pc : addr;
    cnt_en    = ((state == FETCH) || (state == DISCARD)) && !imem_ack;
    req_nxt   = ((next_state == FETCH) && (next_addr[1:0] == 2'b00)) ||
                (next_state == DISCARD);
  end

  // Datapath and registered status outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      cnt         <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      fault_cause <= 2'b00;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      addr <= next_addr;
      if (clr_cnt)     cnt <= '0;
      else if (cnt_en) cnt <= cnt + CW'(1);
      if (cap_instr) begin
        instr    <= imem_rdata;
        instr_pc <= addr;
      end
      if (set_fault) fault_cause <= cause_nxt;
      imem_req    <= req_nxt;
      instr_valid <= (next_state == HOLD);
      fault       <= (next_state == FAULT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset,
// misalignment and timeout sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        pc_load;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        fault;
  logic [1:0]  fault_cause;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .flush(flush), .instr_valid(instr_valid),
    .dec_ready(dec_ready), .instr(instr), .instr_pc(instr_pc),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        flush;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_ipc;
    logic        e_load;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic [63:0] p, logic a, logic [31:0] d, logic f, logic r,
                              logic eq, logic [63:0] ea, logic ev, logic [31:0] ei,
                              logic [63:0] ep, logic el);
    vec_t v;
    v.pc = p; v.ack = a; v.rdata = d; v.flush = f; v.rdy = r;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_ipc = ep; v.e_load = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic [63:0] p);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; flush = 1'b0; dec_ready = 1'b0; imem_rdata = '0; pc = p;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 64'h1000; imem_ack = 1'b0; imem_rdata = '0; flush = 1'b0; dec_ready = 1'b0;

    // Per-cycle table: inputs driven after negedge, outputs checked before next posedge.
    vt[0]  = mk(64'h1000, 0, 32'h0,        0, 0, 0, 64'h0,    0, 32'h0,        64'h0,    0);
    vt[1]  = mk(64'h1000, 1, 32'h00500093, 0, 1, 1, 64'h1000, 0, 32'h0,        64'h0,    0);
    vt[2]  = mk(64'h1004, 0, 32'h0,        0, 1, 0, 64'h0,    1, 32'h00500093, 64'h1000, 1);
    vt[3]  = mk(64'h1004, 0, 32'h0,        0, 0, 1, 64'h1004, 0, 32'h00500093, 64'h1000, 0);
    vt[4]  = mk(64'h1004, 1, 32'h00A00113, 0, 0, 1, 64'h1004, 0, 32'h00500093, 64'h1000, 0);
    for (int i = 5; i < 10; i++)
      vt[i] = mk(64'h1008, 0, 32'h0,       0, 0, 0, 64'h0,    1, 32'h00A00113, 64'h1004, 0);
    vt[10] = mk(64'h1008, 0, 32'h0,        0, 1, 0, 64'h0,    1, 32'h00A00113, 64'h1004, 1);
    vt[11] = mk(64'h1008, 0, 32'h0,        1, 0, 1, 64'h1008, 0, 32'h00A00113, 64'h1004, 0);
    vt[12] = mk(64'h2000, 0, 32'h0,        0, 0, 1, 64'h1008, 0, 32'h00A00113, 64'h1004, 0);
    vt[13] = mk(64'h2000, 0, 32'h0,        0, 0, 1, 64'h1008, 0, 32'h00A00113, 64'h1004, 0);
    vt[14] = mk(64'h2000, 1, 32'hDEADBEEF, 0, 0, 1, 64'h1008, 0, 32'h00A00113, 64'h1004, 0);
    vt[15] = mk(64'h3000, 1, 32'h11111111, 1, 0, 1, 64'h2000, 0, 32'h00A00113, 64'h1004, 0);
    vt[16] = mk(64'h3000, 1, 32'h22222222, 0, 1, 1, 64'h3000, 0, 32'h00A00113, 64'h1004, 0);
    vt[17] = mk(64'h3004, 0, 32'h0,        1, 1, 0, 64'h0,    1, 32'h22222222, 64'h3000, 0);
    vt[18] = mk(64'h3004, 1, 32'h33333333, 0, 0, 1, 64'h3004, 0, 32'h22222222, 64'h3000, 0);
    vt[19] = mk(64'h3004, 0, 32'h0,        0, 0, 0, 64'h0,    1, 32'h33333333, 64'h3004, 0);

    #1;
    check("rst_req",   64'(imem_req),    64'h0);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_load",  64'(pc_load),     64'h0);
    check("rst_fault", 64'(fault),       64'h0);
    check("rst_cause", 64'(fault_cause), 64'h0);
    check("rst_instr", 64'(instr),       64'h0);
    check("rst_ipc",   instr_pc,         64'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      pc = vt[i].pc; imem_ack = vt[i].ack; imem_rdata = vt[i].rdata;
      flush = vt[i].flush; dec_ready = vt[i].rdy;
      #1;
      check($sformatf("v%0d_req", i),   64'(imem_req),    64'(vt[i].e_req));
      if (vt[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("v%0d_valid", i), 64'(instr_valid), 64'(vt[i].e_valid));
      check($sformatf("v%0d_instr", i), 64'(instr),       64'(vt[i].e_instr));
      check($sformatf("v%0d_ipc", i),   instr_pc,         vt[i].e_ipc);
      check($sformatf("v%0d_load", i),  64'(pc_load),     64'(vt[i].e_load));
      check($sformatf("v%0d_fault", i), 64'(fault),       64'h0);
    end

    // Async reset mid-HOLD, then a late ack while in IDLE must be ignored.
    dec_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("ar_valid", 64'(instr_valid), 64'h0);
    check("ar_load",  64'(pc_load),     64'h0);
    check("ar_instr", 64'(instr),       64'h0);
    check("ar_req",   64'(imem_req),    64'h0);
    @(negedge clk);
    dec_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0; pc = 64'h5000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    #1;
    check("ar_resume_req",  64'(imem_req),    64'h1);
    check("ar_resume_addr", imem_addr,        64'h5000);
    check("ar_late_valid",  64'(instr_valid), 64'h0);
    check("ar_late_instr",  64'(instr),       64'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h00000013;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    #1;
    check("ar_fetch_valid", 64'(instr_valid), 64'h1);
    check("ar_fetch_instr", 64'(instr),       64'h00000013);
    check("ar_fetch_ipc",   instr_pc,         64'h5000);

    // Misaligned pc: fault with cause 01, never a request.
    do_reset(64'h1002);
    #1 check("mis_req_idle", 64'(imem_req), 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("mis%0d_req", k),   64'(imem_req),    64'h0);
      check($sformatf("mis%0d_fault", k), 64'(fault),       (k >= 1) ? 64'h1 : 64'h0);
      check($sformatf("mis%0d_cause", k), 64'(fault_cause), (k >= 1) ? 64'h1 : 64'h0);
      check($sformatf("mis%0d_load", k),  64'(pc_load),     64'h0);
    end

    // Timeout with TIMEOUT=8: fault exactly 8 edges after FETCH entry.
    do_reset(64'h4000);
    @(posedge clk);
    #1 check("to_entry_req", 64'(imem_req), 64'h1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("to%0d_fault", k), 64'(fault),       (k >= 8) ? 64'h1 : 64'h0);
      check($sformatf("to%0d_cause", k), 64'(fault_cause), (k >= 8) ? 64'h2 : 64'h0);
      check($sformatf("to%0d_req", k),   64'(imem_req),    (k >= 8) ? 64'h0 : 64'h1);
      check($sformatf("to%0d_valid", k), 64'(instr_valid), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
